// File: rtl/pwm_audio_dac.sv
// pwm_audio_dac: FIFO-buffered 8-bit PWM audio DAC; each sample plays for REPEAT
// 256-cycle PWM periods, and an empty FIFO at slot start plays mid-scale and flags underrun.
module pwm_audio_dac #(
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT     = 4
) (
  input  logic                              clk,
  input  logic                              rst_i,
  input  logic [7:0]                        sample_i,
  input  logic                              sample_valid_i,
  output logic                              sample_ready_o,
  input  logic                              enable_i,
  output logic                              pwm_o,
  output logic                              underrun_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic [7:0] phase, phase_n, cur, cur_n;
  logic [3:0] rpt, rpt_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, load, empty, last;
  assign sample_ready_o = fifo_count_o < CW'(FIFO_DEPTH);
  assign empty = fifo_count_o == '0;
  assign push = sample_valid_i & sample_ready_o;
  assign pop = load & ~empty;
  assign last = phase == 8'hff && rpt == 4'(REPEAT-1);
  always_comb begin
    state_n = state;
    phase_n = phase;
    rpt_n = rpt;
    cur_n = cur;
    load = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      phase_n = '0;
      rpt_n = '0;
      cur_n = 8'd128;
    end else if (state == IDLE) begin
      state_n = PLAY;
      load = 1'b1;
    end else begin
      phase_n = phase + 8'd1;
      rpt_n = phase != 8'hff ? rpt : (last ? 4'd0 : rpt + 4'd1);
      load = last;
    end
    // no bypass: a sample pushed on the load cycle is not yet visible here
    if (load) cur_n = empty ? 8'd128 : mem[rd_ptr];
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      phase <= '0;
      rpt <= '0;
      cur <= 8'd128;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count_o <= '0;
      pwm_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      rpt <= rpt_n;
      cur <= cur_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count_o <= fifo_count_o + CW'(push) - CW'(pop);
      pwm_o <= state == PLAY && phase < cur;
      underrun_o <= load & empty;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_i;
  end
endmodule

// File: tb/tb_pwm_audio_dac.sv
// tb_pwm_audio_dac: directed checks of FIFO flow, PWM duty per slot, underrun and reset.
module tb_pwm_audio_dac;
  logic tb_clk = 1'b0;
  logic rst_i = 1'b0;
  logic [7:0] sample_i = '0;
  logic sample_valid_i = 1'b0;
  logic enable_i = 1'b0;
  logic sample_ready_o, pwm_o, underrun_o;
  logic [2:0] fifo_count_o;
  int checks = 0;
  int errors = 0;
  int hi, ur, first;

  always #5 tb_clk = ~tb_clk;

  pwm_audio_dac dut (
    .clk(tb_clk),
    .rst_i(rst_i),
    .sample_i(sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .enable_i(enable_i),
    .pwm_o(pwm_o),
    .underrun_o(underrun_o),
    .fifo_count_o(fifo_count_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset;
    enable_i = 1'b0;
    sample_valid_i = 1'b0;
    rst_i = 1'b1;
    tick;
    tick;
    rst_i = 1'b0;
    tick;
  endtask

  task automatic push(input logic [7:0] s);
    sample_i = s;
    sample_valid_i = 1'b1;
    tick;
    sample_valid_i = 1'b0;
  endtask

  // window of n cycles: pwm high count, underrun pulse count, first pwm sample
  task automatic run(input int n, output int h, output int u, output int f);
    h = 0;
    u = 0;
    f = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (i == 0) f = int'(pwm_o);
      h += int'(pwm_o);
      u += int'(underrun_o);
    end
  endtask

  initial begin
    #1 rst_i = 1'b1;
    #1;
    check("rst_pwm", int'(pwm_o), 0);
    check("rst_count", int'(fifo_count_o), 0);
    check("rst_ready", int'(sample_ready_o), 1);
    check("rst_underrun", int'(underrun_o), 0);
    do_reset;

    // single sample 64
    push(8'd64);
    check("q64_count", int'(fifo_count_o), 1);
    enable_i = 1'b1;
    tick;
    check("q64_pwm_first_edge", int'(pwm_o), 0);
    check("q64_no_underrun", int'(underrun_o), 0);
    check("q64_popped", int'(fifo_count_o), 0);
    for (int p = 0; p < 4; p++) begin
      run(256, hi, ur, first);
      check($sformatf("q64_hi_p%0d", p), hi, 64);
      check($sformatf("q64_ur_p%0d", p), ur, p == 3 ? 1 : 0);
      if (p == 0) check("q64_first_high", first, 1);
    end
    run(1024, hi, ur, first);
    check("q64_then_mid", hi, 512);

    // fill past full, then playback order
    do_reset;
    sample_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample_i = 8'(10 * (k + 1));
      tick;
      if (k == 3) begin
        check("full_ready", int'(sample_ready_o), 0);
        check("full_count", int'(fifo_count_o), 4);
      end
    end
    sample_valid_i = 1'b0;
    check("full_reject", int'(fifo_count_o), 4);
    enable_i = 1'b1;
    tick;
    check("pop_at_full_count", int'(fifo_count_o), 3);
    check("pop_at_full_ready", int'(sample_ready_o), 1);
    for (int k = 0; k < 4; k++) begin
      run(1024, hi, ur, first);
      check($sformatf("order_hi%0d", k), hi, 40 * (k + 1));
      check($sformatf("order_ur%0d", k), ur, k == 3 ? 1 : 0);
    end
    run(1024, hi, ur, first);
    check("order_after_mid", hi, 512);

    // empty-FIFO underrun repeats until a sample arrives
    do_reset;
    enable_i = 1'b1;
    tick;
    check("empty_ur_pulse", int'(underrun_o), 1);
    run(1024, hi, ur, first);
    check("empty_hi", hi, 512);
    check("empty_ur_repeat", ur, 1);
    push(8'd32);
    check("empty_push_pwm", int'(pwm_o), 1);
    run(1023, hi, ur, first);
    check("empty_rest_hi", hi, 511);
    check("empty_rest_ur", ur, 0);
    run(1024, hi, ur, first);
    check("s32_hi", hi, 128);
    check("s32_next_ur", ur, 1);

    // extremes 0 and 255
    do_reset;
    push(8'd0);
    push(8'd255);
    enable_i = 1'b1;
    tick;
    run(1024, hi, ur, first);
    check("s0_hi", hi, 0);
    for (int p = 0; p < 4; p++) begin
      run(256, hi, ur, first);
      check($sformatf("s255_hi_p%0d", p), hi, 255);
    end

    // push on load cycle, then disable keeps FIFO
    do_reset;
    push(8'd100);
    push(8'd150);
    push(8'd200);
    enable_i = 1'b1;
    tick;
    run(1023, hi, ur, first);
    check("pl_s100_hi", hi, 400);
    check("pl_count_before", int'(fifo_count_o), 2);
    push(8'd210);
    check("pl_count_same", int'(fifo_count_o), 2);
    run(300, hi, ur, first);
    check("pl_s150_hi", hi, 194);
    check("pl_pwm_high", int'(pwm_o), 1);
    enable_i = 1'b0;
    tick;
    tick;
    check("dis_pwm", int'(pwm_o), 0);
    check("dis_count", int'(fifo_count_o), 2);
    enable_i = 1'b1;
    tick;
    run(1024, hi, ur, first);
    check("pl_s200_hi", hi, 800);
    run(1024, hi, ur, first);
    check("pl_s210_hi", hi, 840);
    check("pl_drained", int'(fifo_count_o), 0);

    // asynchronous reset mid-play
    do_reset;
    push(8'd200);
    push(8'd1);
    push(8'd2);
    push(8'd3);
    enable_i = 1'b1;
    tick;
    run(100, hi, ur, first);
    check("mid_pwm_before", int'(pwm_o), 1);
    check("mid_count_before", int'(fifo_count_o), 3);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_pwm", int'(pwm_o), 0);
    check("mid_rst_count", int'(fifo_count_o), 0);
    check("mid_rst_ready", int'(sample_ready_o), 1);
    check("mid_rst_underrun", int'(underrun_o), 0);
    enable_i = 1'b0;
    tick;
    rst_i = 1'b0;
    tick;
    check("post_rst_idle_pwm", int'(pwm_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
